data_mem_responder: RTL
=======================

# data_mem_responder

Memory-mapped data-memory responder for the OpenMIPS minimal SOPC, sitting on the processor's data bus as the target of load/store requests. It accepts one request at a time with a ce/ready handshake and inserts a configurable number of wait states. It performs big-endian byte-lane writes and word reads, and flags out-of-range addresses with an error response.

## Interface
- ADDR_WIDTH, default 10: word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, default 1: wait states inserted between request capture and response; legal range 0..15.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
- mem_ce_i  input  1  request valid; held high by the initiator until ready.
- mem_we_i  input  1  1 = write, 0 = read.
- mem_addr_i  input  32  byte address; bits [1:0] are ignored.
- mem_sel_i  input  4  byte-lane enables; bit 3 is data[31:24] (big-endian).
- mem_data_i  input  32  write data.
- mem_data_o  output  32  read data; valid only while mem_ready_o = 1.
- mem_ready_o  output  1  one-cycle response strobe.
- mem_err_o  output  1  out-of-range flag; valid with mem_ready_o.

## Operation
- The FSM has three states.
  - IDLE: if mem_ce_i = 1, latch we, addr, sel and data. Go to WAIT if WAIT_CYCLES > 0, otherwise go to RESP.
  - WAIT: a 4-bit down-counter is loaded with WAIT_CYCLES-1 at capture. Go to RESP when the counter is 0, otherwise decrement.
  - RESP: mem_ready_o = 1 for exactly this one cycle, then go to IDLE. mem_ce_i is ignored in RESP.
- Range check: the address is out of range if any of latched addr[31:ADDR_WIDTH+2] is nonzero.
  - Out-of-range write: no array write; mem_err_o = 1 in RESP.
  - Out-of-range read: mem_data_o = 0; mem_err_o = 1 in RESP.
- Write: at the edge entering RESP, each byte lane with sel[i] = 1 is updated at word index addr[ADDR_WIDTH+1:2]. Other lanes keep their contents. sel = 0000 is a legal no-op that still gets a ready response.
- Read: returns the full 32-bit word at the captured index, regardless of sel. Lane extraction is the CPU's job.
- Inputs are sampled only in IDLE. Changes to mem_*_i during WAIT or RESP have no effect.
- Array contents are not reset; they are undefined until written.

## Timing
- Reset values while rst = 0: state = IDLE, counter = 0, mem_ready_o = 0, mem_err_o = 0, mem_data_o = 0x00000000.
- All outputs are registered.
- Latency: a request sampled in IDLE at edge N gives mem_ready_o high in cycle N+1+WAIT_CYCLES.
  - Example: with WAIT_CYCLES = 1, ready is high 2 cycles after capture.
- Throughput: at most one request per WAIT_CYCLES+2 cycles.
  - If the initiator keeps ce high through RESP for a new request, that request is captured at the first IDLE edge afterwards.
- mem_data_o holds its value outside RESP, but only the RESP cycle is meaningful.
- Reset during WAIT or RESP:
  - Return to IDLE immediately (asynchronously).
  - A pending write is dropped; the array is untouched.
  - No ready is issued for the aborted request.
- A write and a read to the same word in consecutive requests: the read returns the newly written data, because the write completes before the next capture.

## Structure
- The following go in the shared defines.v:
  - state encodings `MemIdle / `MemWait / `MemResp;
  - `ZeroWord;
  - `DataBus, `DataAddrBus;
  - `RstEnable, redefined to 1'b0 for this active-low block.
- Sub-module data_mem_array: a 2^ADDR_WIDTH × 32 array with four byte-lane write enables, one synchronous write port and one registered read port.
- The top level contains the FSM, wait counter, range check and response registers.

## Test plan
- Word write then read:
  - stimulus: WAIT_CYCLES = 1; write addr 0x00000010, sel 1111, data 0x12345678; then read 0x10;
  - required: each request gets ready exactly 2 cycles after capture; the read returns 0x12345678 with err = 0.
- Byte-lane write:
  - stimulus: after the previous case, write 0xAABBCCDD to 0x10 with sel 0100, then read 0x10;
  - required: read returns 0x12BB5678.
- Out of range:
  - stimulus: ADDR_WIDTH = 10; write 0x00001000, then read 0x00001000;
  - required: both requests give ready with err = 1; the read returns 0x00000000; a read of 0x00000000 afterwards shows no aliasing corruption.
- Zero wait states:
  - stimulus: WAIT_CYCLES = 0; ce held high continuously for 4 back-to-back reads;
  - required: ready pulses every 2nd cycle, giving 4 pulses in 8 cycles.
- Reset mid-operation:
  - stimulus: WAIT_CYCLES = 3; issue a write of 0xDEADBEEF to 0x20; pull rst low during WAIT; then read 0x20;
  - required: no ready pulse for the write; outputs are at reset values while rst = 0; the read does not return 0xDEADBEEF (after a prior write of 0x0 it returns 0x00000000).
- Input change during wait:
  - stimulus: after capturing a read of 0x10, change mem_addr_i to 0x14 in the WAIT state;
  - required: the response carries the data of 0x10.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared types and constants for the
// data-memory responder (states, bus types, captured request).
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        RST_ENABLE = 1'b0;

  typedef logic [31:0] data_bus_t;
  typedef logic [31:0] data_addr_bus_t;

  typedef struct packed {
    logic        we;
    logic [29:0] word;
    logic [3:0]  sel;
    data_bus_t   data;
  } mem_req_t;

  // Any word-address bit above the array index means out of range.
  function automatic logic out_of_range(
    input logic [29:0] word,
    input int          aw
  );
    return (word >> aw) != 30'd0;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: 2^ADDR_WIDTH x 32 storage, byte-lane write port
// (be[3] = data[31:24]) and a registered read port with clear.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic                  rclr,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register only moves on a read response; it holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      rdata <= ZERO_WORD;
    end else if (re) begin
      rdata <= rclr ? ZERO_WORD : mem[raddr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store target with ce/ready handshake,
// WAIT_CYCLES wait states, byte-lane writes and range-error flag.
// Ports: clk, rst (async, active-low), mem_ce_i, mem_we_i,
// mem_addr_i, mem_sel_i, mem_data_i in; mem_data_o, mem_ready_o,
// mem_err_o out (all registered).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_e state;
  mem_state_e nxt;
  mem_req_t   req_q;
  mem_req_t   cur;
  logic [3:0] cnt;
  logic       cap;
  logic       go_resp;
  logic       oor;
  logic       wr_en;
  logic       rd_en;
  logic       unused_bits;

  assign unused_bits = &{1'b0, mem_addr_i[1:0]};

  assign cap = (state == MEM_IDLE) && mem_ce_i;

  // In IDLE the live inputs are the request; afterwards the latch.
  // This lets a zero-wait request act on the capture edge itself.
  always_comb begin
    cur = req_q;
    if (state == MEM_IDLE) begin
      cur.we   = mem_we_i;
      cur.word = mem_addr_i[31:2];
      cur.sel  = mem_sel_i;
      cur.data = mem_data_i;
    end
  end

  assign go_resp = (cap && NO_WAIT) ||
                   ((state == MEM_WAIT) && (cnt == 4'd0));

  assign oor   = out_of_range(cur.word, ADDR_WIDTH);
  assign wr_en = go_resp && cur.we && !oor;
  assign rd_en = go_resp && !cur.we;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state <= MEM_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      MEM_IDLE: begin
        if (mem_ce_i) begin
          nxt = NO_WAIT ? MEM_RESP : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (cnt == 4'd0) begin
          nxt = MEM_RESP;
        end
      end
      MEM_RESP: nxt = MEM_IDLE;
      default:  nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt   <= 4'd0;
      req_q <= '0;
    end else if (cap) begin
      cnt   <= CNT_INIT;
      req_q <= cur;
    end else if ((state == MEM_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      mem_ready_o <= 1'b0;
      mem_err_o   <= 1'b0;
    end else begin
      mem_ready_o <= go_resp;
      mem_err_o   <= go_resp && oor;
    end
  end

  data_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .be    (cur.sel),
    .waddr (cur.word[ADDR_WIDTH-1:0]),
    .wdata (cur.data),
    .re    (rd_en),
    .rclr  (oor),
    .raddr (cur.word[ADDR_WIDTH-1:0]),
    .rdata (mem_data_o)
  );

endmodule
